// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 decode constants for the ID stage.
// Holds opcode values, ALUOp encodings, the immediate-type enum and
// a helper that maps an opcode to the immediate format it carries.
package riscv_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;
    typedef enum logic [1:0] {IMM_NONE, IMM_I, IMM_S, IMM_B} imm_type_e;
    function automatic imm_type_e imm_type(input logic [6:0] op);
        return (op == OP_IALU || op == OP_LOAD) ? IMM_I :
               (op == OP_STORE)                 ? IMM_S :
               (op == OP_BRANCH)                ? IMM_B : IMM_NONE;
    endfunction
endpackage

// File: rtl/regfile.sv
// regfile: NREGS x XLEN register file, two combinational read ports,
// one registered write port, write-through bypass, x0 hardwired to zero.
// Ports: clk, rst (sync, active-high); we/waddr/wdata write port;
// raddr0/raddr1 read addresses; rdata0/rdata1 read data.
module regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr0,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata0,
    output logic [XLEN-1:0] rdata1
);
    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;

    assign wr_en = we && waddr != 5'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[waddr] <= wdata;
        end
    end

    // A write landing this cycle is forwarded so ID sees the new value.
    always_comb begin
        rdata0 = (raddr0 == 5'd0) ? '0 : (wr_en && waddr == raddr0) ? wdata : regs[raddr0];
        rdata1 = (raddr1 == 5'd0) ? '0 : (wr_en && waddr == raddr1) ? wdata : regs[raddr1];
    end
endmodule

// File: rtl/id_stage.sv
// id_stage: RV32 instruction-decode stage with register file, decoder,
// immediate generator and load-use / branch hazard control.
// Ports: clk, rst (sync, active-high); instr/pc_in from IF/ID;
// wb_we/wb_rd/wb_data writeback; idex_memread/idex_rd from ID/EX;
// branch_taken from EX; decoded fields, operands and controls to ID/EX;
// pc_write/ifid_write enables and idex_flush/ifid_flush bubble requests.
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            idex_memread,
    input  logic [4:0]      idex_rd,
    input  logic            branch_taken,
    output logic [XLEN-1:0] Address_in,
    output logic [XLEN-1:0] Immediate_value,
    output logic [XLEN-1:0] Read_data0,
    output logic [XLEN-1:0] Read_data1,
    output logic            ALUSrc,
    output logic            Branch,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            MemtoReg,
    output logic            funct7,
    output logic [1:0]      ALUOp,
    output logic [2:0]      funct3,
    output logic [4:0]      Register_dest,
    output logic [4:0]      IFID_registerRs1,
    output logic [4:0]      IFID_registerRs2,
    output logic            pc_write,
    output logic            ifid_write,
    output logic            idex_flush,
    output logic            ifid_flush
);
    logic [6:0] opcode;
    logic       uses_rs2;
    logic       stall;
    imm_type_e  itype;

    assign opcode           = instr[6:0];
    assign IFID_registerRs1 = instr[19:15];
    assign IFID_registerRs2 = instr[24:20];
    assign Register_dest    = instr[11:7];
    assign funct3           = instr[14:12];
    assign funct7           = instr[30];
    assign Address_in       = pc_in;
    assign itype            = imm_type(opcode);

    regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wb_we),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr0 (instr[19:15]),
        .raddr1 (instr[24:20]),
        .rdata0 (Read_data0),
        .rdata1 (Read_data1)
    );

    always_comb begin
        {ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg} = '0;
        ALUOp = ALUOP_MEM;
        case (opcode)
            OP_R:      begin RegWrite = 1'b1; ALUOp = ALUOP_ARITH; end
            OP_IALU:   begin RegWrite = 1'b1; ALUSrc = 1'b1; ALUOp = ALUOP_ARITH; end
            OP_LOAD:   begin RegWrite = 1'b1; ALUSrc = 1'b1; MemRead = 1'b1; MemtoReg = 1'b1; end
            OP_STORE:  begin MemWrite = 1'b1; ALUSrc = 1'b1; end
            OP_BRANCH: begin Branch = 1'b1; ALUOp = ALUOP_BR; end
            default:   ;
        endcase
    end

    always_comb begin
        Immediate_value = '0;
        case (itype)
            IMM_I:   Immediate_value = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S:   Immediate_value = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   Immediate_value = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            default: ;
        endcase
    end

    // I-type and load encode immediate bits in the rs2 field, so they must not stall on it.
    assign uses_rs2 = opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH;
    assign stall    = idex_memread && idex_rd != 5'd0 &&
                      (idex_rd == instr[19:15] || (uses_rs2 && idex_rd == instr[24:20]));

    // Priority: reset, then branch redirect, then load-use stall.
    always_comb begin
        pc_write   = rst ? 1'b0 : (branch_taken || !stall);
        ifid_write = pc_write;
        idex_flush = rst || branch_taken || stall;
        ifid_flush = rst || branch_taken;
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed self-checking bench for id_stage.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc_in, wb_data;
    logic        wb_we, idex_memread, branch_taken;
    logic [4:0]  wb_rd, idex_rd;
    logic [31:0] Address_in, Immediate_value, Read_data0, Read_data1;
    logic        ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, funct7;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic [4:0]  Register_dest, IFID_registerRs1, IFID_registerRs2;
    logic        pc_write, ifid_write, idex_flush, ifid_flush;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk(clk), .rst(rst), .instr(instr), .pc_in(pc_in),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .idex_memread(idex_memread), .idex_rd(idex_rd), .branch_taken(branch_taken),
        .Address_in(Address_in), .Immediate_value(Immediate_value),
        .Read_data0(Read_data0), .Read_data1(Read_data1),
        .ALUSrc(ALUSrc), .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .funct7(funct7), .ALUOp(ALUOp),
        .funct3(funct3), .Register_dest(Register_dest),
        .IFID_registerRs1(IFID_registerRs1), .IFID_registerRs2(IFID_registerRs2),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_flush(idex_flush), .ifid_flush(ifid_flush)
    );

    function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] d);
        @(negedge clk);
        wb_we = 1'b1; wb_rd = rd; wb_data = d;
        @(posedge clk); #1;
        wb_we = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
        #1;
        checks++;
        if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b0011) begin
            errors++; $display("FAIL rst_ctrl: got %b expected 0011", {pc_write, ifid_write, idex_flush, ifid_flush});
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0; wb_we = 1'b0;
        for (int i = 1; i < 32; i++) begin
            instr = r_add(5'd1, 5'(i), 5'(i)); #1;
            checks++;
            if (Read_data0 !== 32'h0 || Read_data1 !== 32'h0) begin
                errors++; $display("FAIL rst_reg x%0d: got %h/%h expected 0", i, Read_data0, Read_data1);
            end
        end
        checks++;
        if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b1100) begin
            errors++; $display("FAIL post_rst_ctrl: got %b expected 1100", {pc_write, ifid_write, idex_flush, ifid_flush});
        end
    endtask

    task automatic test_x0;
        write_reg(5'd0, 32'hFFFFFFFF);
        @(negedge clk);
        instr = r_add(5'd1, 5'd0, 5'd0); #1;
        checks++;
        if (Read_data0 !== 32'h0 || Read_data1 !== 32'h0) begin
            errors++; $display("FAIL x0: got %h/%h expected 0", Read_data0, Read_data1);
        end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        instr = r_add(5'd1, 5'd5, 5'd6);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678; #1;
        checks++;
        if (Read_data0 !== 32'h12345678) begin
            errors++; $display("FAIL bypass: got %h expected 12345678", Read_data0);
        end
        @(posedge clk); #1;
        wb_we = 1'b0;
        write_reg(5'd6, 32'hCAFEF00D);
        @(negedge clk); #1;
        checks++;
        if (Read_data0 !== 32'h12345678 || Read_data1 !== 32'hCAFEF00D) begin
            errors++; $display("FAIL stored: got %h/%h expected 12345678/cafef00d", Read_data0, Read_data1);
        end
    endtask

    task automatic test_load;
        @(negedge clk);
        instr = 32'hFFC10083; pc_in = 32'h00000400; #1;
        checks++;
        if (Immediate_value !== 32'hFFFFFFFC || Address_in !== 32'h400) begin
            errors++; $display("FAIL lb_imm: got %h pc %h expected fffffffc pc 400", Immediate_value, Address_in);
        end
        checks++;
        if ({RegWrite, ALUSrc, MemRead, MemtoReg, MemWrite, Branch, ALUOp} !== 8'b11110000) begin
            errors++; $display("FAIL lb_ctrl: got %b expected 11110000", {RegWrite, ALUSrc, MemRead, MemtoReg, MemWrite, Branch, ALUOp});
        end
        checks++;
        if (Register_dest !== 5'd1 || IFID_registerRs1 !== 5'd2 || funct3 !== 3'd0) begin
            errors++; $display("FAIL lb_fields: got rd %0d rs1 %0d f3 %0d expected 1 2 0", Register_dest, IFID_registerRs1, funct3);
        end
    endtask

    task automatic test_store;
        @(negedge clk);
        instr = {7'b1111111, 5'd5, 5'd6, 3'b010, 5'b01100, 7'b0100011}; #1;
        checks++;
        if (Immediate_value !== 32'hFFFFFFEC) begin
            errors++; $display("FAIL sw_imm: got %h expected ffffffec", Immediate_value);
        end
        checks++;
        if ({RegWrite, ALUSrc, MemRead, MemtoReg, MemWrite, Branch, ALUOp} !== 8'b01001000) begin
            errors++; $display("FAIL sw_ctrl: got %b expected 01001000", {RegWrite, ALUSrc, MemRead, MemtoReg, MemWrite, Branch, ALUOp});
        end
    endtask

    task automatic test_rtype;
        @(negedge clk);
        instr = {7'b0100000, 5'd3, 5'd2, 3'b000, 5'd1, 7'b0110011}; #1;
        checks++;
        if ({RegWrite, ALUSrc, MemRead, MemtoReg, MemWrite, Branch, ALUOp, funct7} !== 9'b100000101 ||
            Immediate_value !== 32'h0) begin
            errors++; $display("FAIL sub_ctrl: got %b imm %h expected 100000101 imm 0",
                {RegWrite, ALUSrc, MemRead, MemtoReg, MemWrite, Branch, ALUOp, funct7}, Immediate_value);
        end
        instr = {12'h7FF, 5'd1, 3'b111, 5'd9, 7'b0010011}; #1;
        checks++;
        if ({RegWrite, ALUSrc, ALUOp} !== 4'b1110 || Immediate_value !== 32'h000007FF || funct3 !== 3'd7) begin
            errors++; $display("FAIL andi: got %b imm %h f3 %0d expected 1110 imm 7ff f3 7", {RegWrite, ALUSrc, ALUOp}, Immediate_value, funct3);
        end
    endtask

    task automatic test_unknown;
        @(negedge clk);
        instr = 32'hFFFFF0B7; #1;
        checks++;
        if ({RegWrite, ALUSrc, MemRead, MemtoReg, MemWrite, Branch, ALUOp} !== 8'b0 || Immediate_value !== 32'h0) begin
            errors++; $display("FAIL lui_ctrl: got %b imm %h expected 0", {RegWrite, ALUSrc, MemRead, MemtoReg, MemWrite, Branch, ALUOp}, Immediate_value);
        end
    endtask

    task automatic test_beq;
        @(negedge clk);
        instr = 32'hFE000CE3; #1;
        checks++;
        if (Immediate_value !== 32'hFFFFFFF8) begin
            errors++; $display("FAIL beq_imm: got %h expected fffffff8", Immediate_value);
        end
        checks++;
        if ({RegWrite, Branch, ALUOp, MemRead, MemWrite} !== 6'b010100) begin
            errors++; $display("FAIL beq_ctrl: got %b expected 010100", {RegWrite, Branch, ALUOp, MemRead, MemWrite});
        end
    endtask

    task automatic test_stall;
        @(negedge clk);
        idex_memread = 1'b1; idex_rd = 5'd3; instr = r_add(5'd4, 5'd3, 5'd2); #1;
        checks++;
        if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b0010) begin
            errors++; $display("FAIL stall_rs1: got %b expected 0010", {pc_write, ifid_write, idex_flush, ifid_flush});
        end
        @(negedge clk);
        idex_memread = 1'b0; #1;
        checks++;
        if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b1100) begin
            errors++; $display("FAIL stall_next: got %b expected 1100", {pc_write, ifid_write, idex_flush, ifid_flush});
        end
        @(negedge clk);
        idex_memread = 1'b1; instr = r_add(5'd4, 5'd1, 5'd3); #1;
        checks++;
        if (pc_write !== 1'b0 || idex_flush !== 1'b1) begin
            errors++; $display("FAIL stall_rs2: got pw %b fl %b expected 0 1", pc_write, idex_flush);
        end
        instr = {12'h003, 5'd1, 3'b000, 5'd4, 7'b0010011}; #1;
        checks++;
        if (pc_write !== 1'b1 || idex_flush !== 1'b0) begin
            errors++; $display("FAIL nostall_itype: got pw %b fl %b expected 1 0", pc_write, idex_flush);
        end
        idex_rd = 5'd0; instr = r_add(5'd4, 5'd0, 5'd0); #1;
        checks++;
        if (pc_write !== 1'b1 || idex_flush !== 1'b0) begin
            errors++; $display("FAIL nostall_x0: got pw %b fl %b expected 1 0", pc_write, idex_flush);
        end
        idex_memread = 1'b0;
    endtask

    task automatic test_branch_priority;
        @(negedge clk);
        idex_memread = 1'b1; idex_rd = 5'd3; instr = r_add(5'd4, 5'd3, 5'd2); branch_taken = 1'b1; #1;
        checks++;
        if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b1111) begin
            errors++; $display("FAIL br_prio: got %b expected 1111", {pc_write, ifid_write, idex_flush, ifid_flush});
        end
        idex_memread = 1'b0; #1;
        checks++;
        if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b1111) begin
            errors++; $display("FAIL br_only: got %b expected 1111", {pc_write, ifid_write, idex_flush, ifid_flush});
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_reset_mid_stall;
        write_reg(5'd9, 32'h00000055);
        @(negedge clk);
        idex_memread = 1'b1; idex_rd = 5'd9; instr = r_add(5'd1, 5'd9, 5'd10); rst = 1'b1;
        wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'hA5A5A5A5; #1;
        checks++;
        if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b0011) begin
            errors++; $display("FAIL rst_stall: got %b expected 0011", {pc_write, ifid_write, idex_flush, ifid_flush});
        end
        @(negedge clk);
        rst = 1'b0; wb_we = 1'b0; idex_memread = 1'b0; #1;
        checks++;
        if ({pc_write, ifid_write, idex_flush, ifid_flush} !== 4'b1100) begin
            errors++; $display("FAIL after_rst_stall: got %b expected 1100", {pc_write, ifid_write, idex_flush, ifid_flush});
        end
        checks++;
        if (Read_data0 !== 32'h0 || Read_data1 !== 32'h0) begin
            errors++; $display("FAIL rst_clear: got %h/%h expected 0/0", Read_data0, Read_data1);
        end
    endtask

    initial begin
        rst = 1'b1; instr = 32'h0; pc_in = 32'h0; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        idex_memread = 1'b0; idex_rd = 5'd0; branch_taken = 1'b0;
        test_reset;
        test_x0;
        test_bypass;
        test_load;
        test_store;
        test_rtype;
        test_unknown;
        test_beq;
        test_stall;
        test_branch_priority;
        test_reset_mid_stall;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath/register width.
REQ-002 Parameter: NREGS, 32, register count; register address is 5 bits.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 instr  in  32  instruction from the IF/ID register.
REQ-007 pc_in  in  XLEN  PC from the IF/ID register.
REQ-008 wb_we / wb_rd / wb_data  in  1/5/XLEN  writeback port.
REQ-009 idex_memread / idex_rd  in  1/5  MemRead and Rd currently held in ID/EX.
REQ-010 branch_taken  in  1  EX-stage redirect.
REQ-011 Address_in / Immediate_value / Read_data0 / Read_data1  out  XLEN  PC, immediate and operands to ID/EX.
REQ-012 ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg, funct7  out  1 each  control to ID/EX; funct7 = instr[30].
REQ-013 ALUOp  out  2;  funct3  out  3;  Register_dest / IFID_registerRs1 / IFID_registerRs2  out  5 each.
REQ-014 pc_write, ifid_write  out  1  enables for PC and IF/ID; idex_flush, ifid_flush  out  1  bubble requests.

Function
REQ-015 Register file: NREGS x XLEN; the write is registered at posedge clk when wb_we=1 and wb_rd!=0; x0 always reads 0.
REQ-016 Reads are combinational; when wb_we=1, wb_rd!=0 and wb_rd equals the read address, the output is wb_data (write-through bypass).
REQ-017 Decode shall follow the opcode: R 0110011 gives RegWrite=1, ALUOp=10; I-ALU 0010011 gives RegWrite=1, ALUSrc=1, ALUOp=10; load 0000011 gives RegWrite, ALUSrc, MemRead, MemtoReg = 1 and ALUOp=00; store 0100011 gives MemWrite=1, ALUSrc=1, ALUOp=00; branch 1100011 gives Branch=1, ALUOp=01.
REQ-018 Any other opcode drives all control outputs to 0.
REQ-019 Immediate is sign-extended to XLEN: I type from instr[31:20]; S type from {instr[31:25], instr[11:7]}; B type from {instr[31], instr[7], instr[30:25], instr[11:8], 0}; otherwise 0.
REQ-020 Register fields: rs1 = instr[19:15], rs2 = instr[24:20], Register_dest = instr[11:7]; Address_in = pc_in.
REQ-021 rs2 is a source only for R, store and branch types.
REQ-022 Load-use stall condition: idex_memread=1, idex_rd!=0, and idex_rd matches rs1, or matches a used rs2.
REQ-023 While stalled: pc_write=0, ifid_write=0, idex_flush=1; the stall holds exactly one cycle per hazard, since ID/EX then carries a bubble.
REQ-024 When branch_taken=1: idex_flush=1 and ifid_flush=1, with pc_write=1.
REQ-025 branch_taken has priority over a simultaneous stall: pc_write=1 and ifid_write=1.
REQ-026 Outside stall and branch: pc_write=ifid_write=1, idex_flush=ifid_flush=0.
REQ-027 Decode-to-output latency is 0 cycles (combinational); only the register file holds state.

Reset
REQ-028 When rst=1 at posedge clk, all registers clear to 0; a wb_we in the same cycle is ignored.
REQ-029 During rst, pc_write=ifid_write=0 and idex_flush=ifid_flush=1.
REQ-030 Reset asserted mid-stall cancels the stall; the cycle after deassertion follows REQ-026.

Structure
REQ-031 Opcode constants, ALUOp encodings and the immediate-type enum shall reside in the shared package riscv_pkg.
REQ-032 The register file shall be a sub-module regfile (two read ports, one write port, bypass) instantiated once.
REQ-033 Decoder, immediate generator and hazard logic shall be in-module combinational logic.

Verification
REQ-034 Reset, then read x1..x31 -> all read 0; wb_we to x0 with 0xFFFFFFFF -> x0 still reads 0.
REQ-035 Write x5=0x12345678 with instr reading rs1=x5 in the same cycle -> Read_data0=0x12345678 (bypass).
REQ-036 instr=0xFFC10083 (lb x1,-4(x2)) -> Immediate_value=0xFFFFFFFC, MemRead=1, MemtoReg=1, ALUOp=00, Register_dest=1.
REQ-037 idex_memread=1, idex_rd=3; instr add x4,x3,x2 -> one-cycle stall: pc_write=0, ifid_write=0, idex_flush=1; the next cycle with idex_memread=0 is normal.
REQ-038 Stall condition and branch_taken=1 together -> pc_write=1, idex_flush=1, ifid_flush=1.
REQ-039 instr beq with imm=-8 (0xFE000CE3) -> Immediate_value=0xFFFFFFF8, Branch=1, ALUOp=01, RegWrite=0.
